gcd_core: RTL



---
 rtl/gcd_pkg.sv | 16 +
 rtl/gcd_datapath.sv | 74 +++++++
 rtl/gcd_core.sv | 113 +++++++++++
 3 files changed

// File: rtl/gcd_pkg.sv
// gcd_pkg
//   Shared definitions for the GCD engine: controller state encoding and
//   the default operand width used by the engine and its wrappers.
`timescale 1ns/1ps

package gcd_pkg;

    localparam int GCD_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } gcd_state_e;

endpackage : gcd_pkg

// File: rtl/gcd_datapath.sv
// gcd_datapath
//   Operand and result registers of the subtractive-Euclid GCD engine,
//   plus the comparator and subtractor that drive one iteration per clock.
//
// Ports
//   clk_i        : system clock
//   nreset_i     : asynchronous active-low reset
//   i_load       : capture i_operand_a / i_operand_b into the working regs
//   i_step       : perform one subtract step (larger minus smaller)
//   i_capture    : latch the terminating value into the result register
//   i_operand_a  : operand A
//   i_operand_b  : operand B
//   o_result     : registered GCD result
//   o_finish     : current operands meet a termination condition
`timescale 1ns/1ps

module gcd_datapath
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH_DEFAULT
) (
    input  logic             clk_i,
    input  logic             nreset_i,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_capture,
    input  logic [WIDTH-1:0] i_operand_a,
    input  logic [WIDTH-1:0] i_operand_b,
    output logic [WIDTH-1:0] o_result,
    output logic             o_finish
);

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;

    logic             w_a_gt_b;
    logic [WIDTH-1:0] w_diff;

    assign w_a_gt_b = (r_a > r_b);
    // Always larger minus smaller, so the difference never wraps.
    assign w_diff   = w_a_gt_b ? (r_a - r_b) : (r_b - r_a);
    assign o_finish = (r_a == '0) || (r_b == '0) || (r_a == r_b);
    assign o_result = r_result;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values; blocking here would chain the updates.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            r_a <= '0;
            r_b <= '0;
        end else if (i_load) begin
            r_a <= i_operand_a;
            r_b <= i_operand_b;
        end else if (i_step) begin
            if (w_a_gt_b) begin
                r_a <= w_diff;
            end else begin
                r_b <= w_diff;
            end
        end
    end

    // On every termination condition a|b is the answer: with a zero operand
    // it is the other operand, and with a==b it equals a.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            r_result <= '0;
        end else if (i_capture) begin
            r_result <= r_a | r_b;
        end
    end

endmodule : gcd_datapath

// File: rtl/gcd_core.sv
// gcd_core
//   Iterative subtractive-Euclid GCD engine. A rising edge on the
//   synchronised enable loads both operands; one subtract step runs per
//   clock; the result is offered on a valid/ready handshake. Dropping the
//   enable during calculation aborts; dropping it while the result waits
//   does not.
//
// Ports
//   clk_i          : system clock
//   nreset_i       : asynchronous active-low reset
//   gcd_enable_i   : synchronised enable level (rising edge starts)
//   operand_a_i    : operand A, sampled on the load edge only
//   operand_b_i    : operand B, sampled on the load edge only
//   result_ready_i : consumer accepts the result while result_valid_o is high
//   result_o       : GCD result, held while result_valid_o is high
//   result_valid_o : result available (DONE state)
//   busy_o         : computation in progress (CALC state)
`timescale 1ns/1ps

module gcd_core
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH_DEFAULT
) (
    input  logic             clk_i,
    input  logic             nreset_i,
    input  logic             gcd_enable_i,
    input  logic [WIDTH-1:0] operand_a_i,
    input  logic [WIDTH-1:0] operand_b_i,
    input  logic             result_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             result_valid_o,
    output logic             busy_o
);

    gcd_state_e r_state;
    gcd_state_e w_state_next;
    logic       r_enable_q;

    logic       w_start;
    logic       w_load;
    logic       w_step;
    logic       w_capture;
    logic       w_finish;

    // Enable history resets low, so an enable already high when reset
    // releases is seen as a rising edge.
    assign w_start = gcd_enable_i & ~r_enable_q;

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            r_state    <= IDLE;
            r_enable_q <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_enable_q <= gcd_enable_i;
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_load       = 1'b1;
                    w_state_next = CALC;
                end
            end
            CALC: begin
                if (!gcd_enable_i) begin
                    w_state_next = IDLE;
                end else if (w_finish) begin
                    w_capture    = 1'b1;
                    w_state_next = DONE;
                end else begin
                    w_step       = 1'b1;
                end
            end
            DONE: begin
                if (result_ready_i) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Status outputs decode straight from the state flops.
    assign busy_o         = (r_state == CALC);
    assign result_valid_o = (r_state == DONE);

    gcd_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk_i       (clk_i),
        .nreset_i    (nreset_i),
        .i_load      (w_load),
        .i_step      (w_step),
        .i_capture   (w_capture),
        .i_operand_a (operand_a_i),
        .i_operand_b (operand_b_i),
        .o_result    (result_o),
        .o_finish    (w_finish)
    );

endmodule : gcd_core
